// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch stage.
// Drives byte fetch addresses IA0/IA1 to the instruction memory, captures the
// returned halfword into a DEPTH-entry FIFO together with its byte address,
// and presents the head to the decoder over a valid/ready handshake.
// A redirect flushes the queue and restarts fetch at a new halfword address.
//
// Optional build macro: FETCH_QUEUE_BYPASS_EN
//   When defined, an empty queue forwards the fetched halfword straight to
//   the decoder in the same cycle (0-cycle fetch-to-issue latency).
//   When undefined, the head is always taken from the registered queue.
module fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [9:0]  IA0,
  output logic [9:0]  IA1,
  input  logic [15:0] PreInstruction,
  output logic [15:0] instr,
  output logic [9:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [9:0]  redirect_pc,
  output logic [3:0]  fill_level
);

  // Pointer width; DEPTH is a power of two so pointers wrap on their own.
  localparam int         PTR_W       = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C     = 4'(DEPTH);
  localparam logic [9:0] RESET_PC_C  = 10'(RESET_PC);
  localparam logic [9:0] HALFWORD_MASK = 10'h3FE;

  // Architectural state
  logic [9:0]       fetch_pc;
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [3:0]       count;

  // Queue storage: one halfword and its byte address per entry
  logic [15:0]      q_instr [DEPTH];
  logic [9:0]       q_pc    [DEPTH];

  // Last head shown to the decoder, kept visible while the queue is empty
  logic [15:0]      held_instr;
  logic [9:0]       held_pc;

  // Handshake / queue control
  logic             queue_empty;
  logic             pop;
  logic             push;
  logic             bypass_take;
  logic             q_push;
  logic             q_pop;

  assign queue_empty = (count == 4'd0);

  // Fetch addresses are a pure function of fetch_pc
  assign IA0        = fetch_pc;
  assign IA1        = fetch_pc + 10'd1;
  assign fill_level = count;

  // Select what the decoder sees: queue head, bypassed fetch, or held value
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    instr_valid = !queue_empty;
    instr       = queue_empty ? held_instr : q_instr[head_ptr];
    instr_pc    = queue_empty ? held_pc    : q_pc[head_ptr];
`ifdef FETCH_QUEUE_BYPASS_EN
    if (queue_empty && !redirect) begin
      instr_valid = 1'b1;
      instr       = PreInstruction;
      instr_pc    = fetch_pc;
    end
`endif
  end

  // Derive push/pop; redirect overrides both
  always_comb begin
    pop  = instr_valid && instr_ready && !redirect;
    push = !redirect && ((count < DEPTH_C) || pop);
`ifdef FETCH_QUEUE_BYPASS_EN
    // An empty queue with a consuming decoder hands the fetch over directly
    bypass_take = queue_empty && pop;
`else
    bypass_take = 1'b0;
`endif
    q_push = push && !bypass_take;
    q_pop  = pop && !queue_empty;
  end

  // Fetch address register: reset, redirect, or advance one halfword per push
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset) begin
      fetch_pc <= RESET_PC_C;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & HALFWORD_MASK;
    end else if (push) begin
      fetch_pc <= fetch_pc + 10'd2;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clock) begin
    if (!reset || redirect) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= 4'd0;
    end else begin
      if (q_push) begin
        tail_ptr <= tail_ptr + PTR_W'(1);
      end
      if (q_pop) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
      count <= count + {3'b000, q_push} - {3'b000, q_pop};
    end
  end

  // Queue storage write at the tail
  always_ff @(posedge clock) begin
    // NOTE: the storage array is deliberately not reset; an entry is only
    // read once count says it was written, so clearing it buys nothing.
    if (reset && q_push) begin
      q_instr[tail_ptr] <= PreInstruction;
      q_pc[tail_ptr]    <= fetch_pc;
    end
  end

  // Remember the last valid head so outputs hold while the queue is empty
  always_ff @(posedge clock) begin
    if (!reset) begin
      held_instr <= 16'h0000;
      held_pc    <= 10'h000;
    end else if (instr_valid) begin
      held_instr <= instr;
      held_pc    <= instr_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH    = 4;
  localparam int RESET_PC = 0;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [15:0] i;
    logic [9:0]  pc;
  } entry_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  IA0, IA1;
  logic [15:0] PreInstruction;
  logic [15:0] instr;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [9:0]  redirect_pc;
  logic [3:0]  fill_level;

  logic [7:0]  mem [1024];

  int errors = 0;
  int checks = 0;

  // Reference model state
  entry_t      mq[$];
  int          m_fpc;
  logic [15:0] m_held_i;
  logic [9:0]  m_held_pc;
  bit          model_ok = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock         (clock),
    .reset         (reset),
    .IA0           (IA0),
    .IA1           (IA1),
    .PreInstruction(PreInstruction),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .fill_level    (fill_level)
  );

  always #5 clock = ~clock;

  // Byte-wide instruction memory answering combinationally
  assign PreInstruction = {mem[IA1], mem[IA0]};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_half(input int a);
    return {mem[(a + 1) % 1024], mem[a % 1024]};
  endfunction

  // What the decoder must see this cycle, from model state and current inputs
  function automatic void model_view(output logic v, output logic [15:0] i, output logic [9:0] pc);
    v  = (mq.size() != 0);
    i  = v ? mq[0].i  : m_held_i;
    pc = v ? mq[0].pc : m_held_pc;
    if (BYPASS && mq.size() == 0 && !redirect) begin
      v  = 1'b1;
      i  = mem_half(m_fpc);
      pc = 10'(m_fpc);
    end
  endfunction

  // Compare every DUT output with the model
  task automatic compare();
    logic v; logic [15:0] i; logic [9:0] pc;
    model_view(v, i, pc);
    check("ia0",         32'(IA0),         32'(m_fpc));
    check("ia1",         32'(IA1),         32'((m_fpc + 1) % 1024));
    check("fill_level",  32'(fill_level),  32'(mq.size()));
    check("instr_valid", 32'(instr_valid), 32'(v));
    check("instr",       32'(instr),       32'(i));
    check("instr_pc",    32'(instr_pc),    32'(pc));
  endtask

  // Advance the model by one clock edge using the inputs held across it
  task automatic model_advance();
    logic v; logic [15:0] i; logic [9:0] pc;
    bit pop, push, byp;
    if (!reset) begin
      mq.delete();
      m_fpc     = RESET_PC;
      m_held_i  = '0;
      m_held_pc = '0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      model_view(v, i, pc);
      if (v) begin
        m_held_i  = i;
        m_held_pc = pc;
      end
      if (redirect) begin
        mq.delete();
        m_fpc = int'(redirect_pc) & 'h3FE;
      end else begin
        pop  = v && instr_ready;
        byp  = BYPASS && mq.size() == 0 && pop;
        push = (mq.size() < DEPTH) || pop;
        if (pop && mq.size() != 0) void'(mq.pop_front());
        if (push && !byp) mq.push_back('{i: mem_half(m_fpc), pc: 10'(m_fpc)});
        if (push) m_fpc = (m_fpc + 2) % 1024;
      end
    end
  endtask

  // Apply inputs for the coming cycle and compare once they have settled
  task automatic drive(input logic rst, input logic rdy, input logic red, input logic [9:0] rpc);
    reset       = rst;
    instr_ready = rdy;
    redirect    = red;
    redirect_pc = rpc;
    #1;
    if (model_ok) compare();
  endtask

  task automatic tick();
    @(posedge clock);
    model_advance();
    @(negedge clock);
  endtask

  logic [9:0] prev_ia0;
  logic [9:0] popped[$];

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom_range(0, 255));
    mem[10'h3FC] = 8'h00; mem[10'h3FD] = 8'hE8;   // out-of-range fill value

    // Reset, then fill with the decoder stalled
    drive(1'b0, 1'b0, 1'b0, 10'h0);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 1'b0, 10'h0);
      check("fill_ia0", 32'(IA0), (k < 4) ? 32'(2 * k) : 32'd8);
      check("fill_lvl", 32'(fill_level), (k < 4) ? 32'(k) : 32'd4);
      if (k == 0) begin
        check("rst_ia1", 32'(IA1), 32'd1);
        if (!BYPASS) begin
          check("rst_valid", 32'(instr_valid), 32'd0);
          check("rst_instr", 32'(instr), 32'd0);
          check("rst_pc",    32'(instr_pc), 32'd0);
        end
      end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 10'h0);
    check("head_pc",    32'(instr_pc), 32'd0);
    check("head_instr", 32'(instr), 32'(mem_half(0)));

    // Redirect while full to an odd target
    drive(1'b1, 1'b0, 1'b1, 10'h031);
    tick();
    drive(1'b1, 1'b0, 1'b0, 10'h0);
    check("redir_fill", 32'(fill_level), 32'd0);
    check("redir_ia0",  32'(IA0), 32'h30);
    check("redir_ia1",  32'(IA1), 32'h31);
    if (!BYPASS) check("redir_valid", 32'(instr_valid), 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 10'h0);
    check("redir_pc",    32'(instr_pc), 32'h30);
    check("redir_valid2", 32'(instr_valid), 32'd1);
    tick();

    // Top up to full, then pop while full
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 10'h0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b0, 10'h0);
      check("fullpop_fill", 32'(fill_level), 32'd4);
      check("fullpop_pc",   32'(instr_pc), 32'(10'h30 + 10'(2 * k)));
      if (k > 0) check("fullpop_ia0", 32'(IA0), 32'(prev_ia0 + 10'd2));
      prev_ia0 = IA0;
      tick();
    end

    // Streaming from reset
    drive(1'b0, 1'b1, 1'b0, 10'h0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b0, 10'h0);
      if (BYPASS) begin
        check("stream_pc",   32'(instr_pc), 32'(2 * k));
        check("stream_fill", 32'(fill_level), 32'd0);
      end else if (k > 0) begin
        check("stream_pc",   32'(instr_pc), 32'(2 * (k - 1)));
        check("stream_fill", 32'(fill_level), 32'd1);
      end
      tick();
    end

    // Wrap-around at the top of the address space
    drive(1'b1, 1'b1, 1'b1, 10'h3FC);
    tick();
    popped.delete();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 1'b0, 10'h0);
      if (instr_valid) popped.push_back(instr_pc);
      if (IA0 == 10'h3FE) check("wrap_ia1", 32'(IA1), 32'h3FF);
      tick();
    end
    check("wrap_n", 32'(popped.size() >= 3), 32'd1);
    if (popped.size() >= 3) begin
      check("wrap_pc0", 32'(popped[0]), 32'h3FC);
      check("wrap_pc1", 32'(popped[1]), 32'h3FE);
      check("wrap_pc2", 32'(popped[2]), 32'h000);
    end

    // Reset mid-stream with three entries queued
    drive(1'b1, 1'b0, 1'b1, 10'h100);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 10'h0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 10'h0);
    check("midrst_pre_fill", 32'(fill_level), 32'd3);
    tick();
    drive(1'b1, 1'b0, 1'b0, 10'h0);
    check("midrst_fill", 32'(fill_level), 32'd0);
    check("midrst_ia0",  32'(IA0), 32'(RESET_PC));
    if (!BYPASS) check("midrst_valid", 32'(instr_valid), 32'd0);
    tick();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0),
            10'($urandom_range(0, 1023)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch stage sitting directly downstream of the external memory's instruction port. It drives the two byte fetch addresses `IA0`/`IA1`, captures the returned 16-bit `PreInstruction` into a small FIFO, and hands halfword instructions with their PC to the decoder over a valid/ready handshake. A redirect input flushes the queue and restarts fetch at a new halfword address.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2..8.
- `RESET_PC`, 0: fetch address after reset; even, 10 bits.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clock`.
- `IA0`  out  10  low-byte fetch address, equal to `fetch_pc`.
- `IA1`  out  10  high-byte fetch address, equal to `fetch_pc + 1` (mod 1024).
- `PreInstruction`  in  16  `{byte@IA1, byte@IA0}` from memory, valid combinationally in the same cycle.
- `instr`  out  16  head-of-queue instruction.
- `instr_pc`  out  10  byte address of `instr`.
- `instr_valid`  out  1  `instr`/`instr_pc` are meaningful.
- `instr_ready`  in  1  decoder accepts the head this cycle.
- `redirect`  in  1  flush the queue and restart fetch.
- `redirect_pc`  in  10  new fetch address; bit 0 is ignored and forced to 0.
- `fill_level`  out  4  number of occupied entries, 0..DEPTH.

## Operation
- `fetch_pc` is a 10-bit register. `IA0` = `fetch_pc` and `IA1` = `fetch_pc + 1` are combinational from it.
- push = `!redirect && (count < DEPTH || pop)`. On a push, `{PreInstruction, fetch_pc}` is written at the tail and `fetch_pc <= fetch_pc + 2`, wrapping modulo 1024 (1022 goes to 0).
- pop = `instr_valid && instr_ready && !redirect`. On a pop the head advances.
- Simultaneous push and pop: count is unchanged. Push is allowed when full only if pop is also asserted.
- Redirect has priority over push and pop.
  - count <= 0; head and tail pointers are reset.
  - `fetch_pc <= {redirect_pc[9:1],1'b0}`.
  - Nothing is written that cycle.
- The memory's out-of-range fill value `16'hE800` is queued like any other halfword; no special handling.
- `instr_valid` = (count != 0); `fill_level` = count.
- When `instr_valid` = 0, `instr` and `instr_pc` hold their last value; after reset they are 0.
- Pointers are log2(DEPTH) bits and wrap naturally. count is 4 bits.
- Reset values (`reset` = 0 at an edge):
  - `fetch_pc` = RESET_PC, so `IA0` = RESET_PC and `IA1` = RESET_PC+1.
  - count = 0, pointers = 0, `instr_valid` = 0, `instr` = 0, `instr_pc` = 0, `fill_level` = 0.
- Reset has priority over redirect. Reset mid-operation discards all entries regardless of `instr_ready`.

## Timing
- Fetch-to-issue latency is 1 cycle, and 0 cycles with the bypass option (see Configuration).
  - A halfword presented in cycle N is at the head with `instr_valid` = 1 in cycle N+1, if the queue was empty.
- First cycle with `reset` = 1: `IA0` = RESET_PC. `instr_valid` rises in the following cycle.
- Redirect asserted in cycle N:
  - Cycle N+1: `instr_valid` = 0 and `IA0` = redirect target.
  - Cycle N+2: first new instruction is valid.
- Throughput with `instr_ready` held at 1 is one instruction per cycle, and the queue holds at count 1.
- With `instr_ready` held at 0, the queue fills to DEPTH in DEPTH cycles. `fetch_pc` then stalls and `IA0` stays constant.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - When count = 0 and `redirect` = 0, `instr_valid` = 1 combinationally, with `instr` = `PreInstruction` and `instr_pc` = `fetch_pc`.
  - If `instr_ready` is also 1, the fetched halfword is consumed directly. `fetch_pc` advances by 2 and nothing is written to the queue.
  - If `instr_ready` is 0, it is pushed normally.
- Without the macro, `instr_valid` depends only on count (registered path, 1-cycle latency).

## Test plan
- Reset and fill, macro off: RESET_PC=0, `PreInstruction` = `{IA1,IA0}` byte model, `instr_ready` = 0.
  - Required: `IA0` steps 0,2,4,6 then holds at 8; `fill_level` reaches 4.
  - Required: head `instr_pc` = 0 with `instr` = memory halfword at 0.
- Streaming: `instr_ready` = 1 from reset.
  - Required: `instr_pc` sequence 0,2,4,6,… one per cycle, `fill_level` steady at 1.
  - Bypass build: `instr_pc` = 0 in the first cycle and `fill_level` stays 0.
- Redirect while full with `redirect_pc` = 0x31.
  - Next cycle: `instr_valid` = 0, `fill_level` = 0, `IA0` = 0x30, `IA1` = 0x31.
  - Cycle after: `instr_pc` = 0x30.
- Full with simultaneous pop.
  - Required: count stays 4, `IA0` advances by 2, and the order of popped `instr_pc` values is preserved.
- Wrap-around: redirect to 0x3FC.
  - Required: `instr_pc` = 0x3FC, 0x3FE, 0x000.
  - Required: at 0x3FE, `IA1` = 0x3FF.
- Reset mid-stream: `reset` = 0 for one edge while `fill_level` = 3.
  - Required: `fill_level` = 0, `instr_valid` = 0, `IA0` = RESET_PC on the next cycle.
